// File: rtl/hs_npu_line_mover.sv
// hs_npu_line_mover: moves memory lines to/from NPU lanes with INT8/INT16 unpack and saturating pack
//   cmd_*   : command handshake, direction, element mode, base address, stride, line count
//   mem_*   : line address, read-data handshake/data, write handshake/data
//   lane_*  : load-side unpacked lane output handshake
//   st_*    : store-side lane input handshake
//   busy_o, done_o, lines_done_o : status
module hs_npu_line_mover #(
  parameter int SIZE = 8,
  parameter int LANE_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int LINES_WIDTH = 16,
  localparam int MEM_WORDS = SIZE / 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic                         cmd_dir_i,
  input  logic                         cmd_mode_i,
  input  logic [ADDR_WIDTH-1:0]        cmd_base_i,
  input  logic [ADDR_WIDTH-1:0]        cmd_stride_i,
  input  logic [LINES_WIDTH-1:0]       cmd_lines_i,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  input  logic                         mem_rvalid_i,
  output logic                         mem_rready_o,
  input  logic [MEM_WORDS*32-1:0]      mem_rdata_i,
  output logic                         mem_wvalid_o,
  input  logic                         mem_wready_i,
  output logic [MEM_WORDS*32-1:0]      mem_wdata_o,
  output logic                         lane_valid_o,
  input  logic                         lane_ready_i,
  output logic [SIZE*LANE_WIDTH-1:0]   lane_data_o,
  input  logic                         st_valid_i,
  output logic                         st_ready_o,
  input  logic [SIZE*LANE_WIDTH-1:0]   st_data_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [LINES_WIDTH-1:0]       lines_done_o
);
  typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d, addr_q, addr_d;
  logic [LINES_WIDTH-1:0] lines_q, lines_d, lines_done_q, lines_done_d;
  logic lane_valid_q, lane_valid_d, mem_wvalid_q, mem_wvalid_d, done_q, done_d;
  logic [SIZE*LANE_WIDTH-1:0] lane_data_q, lane_data_d, unpacked;
  logic [MEM_WORDS*32-1:0] mem_wdata_q, mem_wdata_d, packed_line;
  logic rd_beat, st_beat, wr_done, rd_last, st_last;
  // Saturation by checking that all bits above the target sign bit match it
  function automatic logic [7:0] sat8(input logic [LANE_WIDTH-1:0] v);
    return (&v[LANE_WIDTH-1:7] | ~|v[LANE_WIDTH-1:7]) ? v[7:0] : {v[LANE_WIDTH-1], {7{~v[LANE_WIDTH-1]}}};
  endfunction
  function automatic logic [15:0] sat16(input logic [LANE_WIDTH-1:0] v);
    return (&v[LANE_WIDTH-1:15] | ~|v[LANE_WIDTH-1:15]) ? v[15:0] : {v[LANE_WIDTH-1], {15{~v[LANE_WIDTH-1]}}};
  endfunction
  assign cmd_ready_o  = state_q == IDLE;
  assign busy_o       = state_q != IDLE;
  assign mem_rready_o = (state_q == LOAD) & (~lane_valid_q | lane_ready_i);
  assign st_ready_o   = (state_q == STORE) & (~mem_wvalid_q | mem_wready_i);
  assign rd_beat      = mem_rvalid_i & mem_rready_o;
  assign st_beat      = st_valid_i & st_ready_o;
  assign wr_done      = mem_wvalid_q & mem_wready_i;
  assign rd_last      = (lines_done_q + LINES_WIDTH'(1)) == lines_q;
  // Lines accepted so far on the store side = completed writes plus the one still pending
  assign st_last      = (lines_done_q + LINES_WIDTH'(mem_wvalid_q) + LINES_WIDTH'(1)) == lines_q;
  assign mem_addr_o   = addr_q;
  assign mem_wvalid_o = mem_wvalid_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign lane_valid_o = lane_valid_q;
  assign lane_data_o  = lane_data_q;
  assign done_o       = done_q;
  assign lines_done_o = lines_done_q;
  always_comb begin
    unpacked = '0;
    packed_line = '0;
    for (int k = 0; k < SIZE; k++) begin
      unpacked[k*LANE_WIDTH +: LANE_WIDTH] = mode_q ? LANE_WIDTH'($signed(mem_rdata_i[16*k +: 16]))
                                                    : LANE_WIDTH'($signed(mem_rdata_i[8*k +: 8]));
      if (mode_q) packed_line[16*k +: 16] = sat16(st_data_i[k*LANE_WIDTH +: LANE_WIDTH]);
      else        packed_line[8*k +: 8]   = sat8(st_data_i[k*LANE_WIDTH +: LANE_WIDTH]);
    end
  end
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    stride_d     = stride_q;
    lines_d      = lines_q;
    done_d       = 1'b0;
    lane_valid_d = rd_beat | (lane_valid_q & ~lane_ready_i);
    lane_data_d  = rd_beat ? unpacked : lane_data_q;
    mem_wvalid_d = st_beat | (mem_wvalid_q & ~mem_wready_i);
    mem_wdata_d  = st_beat ? packed_line : mem_wdata_q;
    addr_d       = (rd_beat | wr_done) ? addr_q + stride_q : addr_q;
    lines_done_d = (rd_beat | wr_done) ? lines_done_q + LINES_WIDTH'(1) : lines_done_q;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        mode_d       = cmd_mode_i;
        stride_d     = cmd_stride_i;
        lines_d      = cmd_lines_i;
        addr_d       = cmd_base_i;
        lines_done_d = '0;
        state_d      = (cmd_lines_i == '0) ? DRAIN : cmd_dir_i ? STORE : LOAD;
      end
      LOAD:  if (rd_beat & rd_last) state_d = DRAIN;
      STORE: if (st_beat & st_last) state_d = DRAIN;
      // Common exit for both directions: last lane consumed and last write completed
      DRAIN: if ((~lane_valid_q | lane_ready_i) & (~mem_wvalid_q | mem_wready_i)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      stride_q     <= '0;
      lines_q      <= '0;
      addr_q       <= '0;
      lines_done_q <= '0;
      lane_valid_q <= 1'b0;
      lane_data_q  <= '0;
      mem_wvalid_q <= 1'b0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      stride_q     <= stride_d;
      lines_q      <= lines_d;
      addr_q       <= addr_d;
      lines_done_q <= lines_done_d;
      lane_valid_q <= lane_valid_d;
      lane_data_q  <= lane_data_d;
      mem_wvalid_q <= mem_wvalid_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
    end
  end
endmodule

// File: tb/tb_hs_npu_line_mover.sv
// tb_hs_npu_line_mover: randomized and directed checks of hs_npu_line_mover against a line-level model
module tb_hs_npu_line_mover;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic cmd_valid_i = 0, cmd_ready_o, cmd_dir_i = 0, cmd_mode_i = 0;
  logic [31:0] cmd_base_i = 0, cmd_stride_i = 0, mem_addr_o;
  logic [15:0] cmd_lines_i = 0, lines_done_o;
  logic mem_rvalid_i = 0, mem_rready_o, mem_wvalid_o, mem_wready_i = 0;
  logic [127:0] mem_rdata_i, mem_wdata_o, lane_data_o, st_data_i = 0;
  logic lane_valid_o, lane_ready_i = 0, st_valid_i = 0, st_ready_o, busy_o, done_o;
  int vecs = 0, errs = 0, n_rd, n_wr, done_cnt;
  bit hold, exp_mode;
  logic [127:0] held, lv;
  logic [127:0] q_lane[$], q_wr[$], lane_log[$];
  logic [31:0] addr_log[$], exp_base, exp_stride, ea;
  hs_npu_line_mover dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_dir_i(cmd_dir_i), .cmd_mode_i(cmd_mode_i),
    .cmd_base_i(cmd_base_i), .cmd_stride_i(cmd_stride_i), .cmd_lines_i(cmd_lines_i),
    .mem_addr_o(mem_addr_o), .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o), .mem_rdata_i(mem_rdata_i),
    .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i), .mem_wdata_o(mem_wdata_o),
    .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i), .lane_data_o(lane_data_o),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_data_i(st_data_i),
    .busy_o(busy_o), .done_o(done_o), .lines_done_o(lines_done_o)
  );
  // Memory contents are a pure function of address; line 0x100 word 0 is 0x80FF017F
  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a * 32'h9E3779B1, ~a, a + 32'h01234567, 32'h80FF017F ^ (a - 32'h100)};
  endfunction
  assign mem_rdata_i = line_of(mem_addr_o);
  function automatic logic [127:0] unpack_m(input logic [127:0] line, input bit m);
    logic [127:0] r = '0;
    for (int k = 0; k < 8; k++) begin
      int v;
      v = m ? int'(line[16*k +: 16]) : int'(line[8*k +: 8]);
      if (m && v > 32767) v -= 65536;
      if (!m && v > 127) v -= 256;
      r[16*k +: 16] = v[15:0];
    end
    return r;
  endfunction
  function automatic logic [127:0] pack_m(input logic [127:0] lanes, input bit m);
    logic [127:0] r = '0;
    for (int k = 0; k < 8; k++) begin
      int v, lo, hi;
      v = int'($signed(lanes[16*k +: 16]));
      lo = m ? -32768 : -128;
      hi = m ? 32767 : 127;
      v = v < lo ? lo : v > hi ? hi : v;
      if (m) r[16*k +: 16] = v[15:0];
      else r[8*k +: 8] = v[7:0];
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) hold = 0;
    else begin
      if (mem_rvalid_i && mem_rready_o) begin
        ea = exp_base + n_rd * exp_stride;
        chk("rd_addr", mem_addr_o, ea);
        q_lane.push_back(unpack_m(mem_rdata_i, exp_mode));
        addr_log.push_back(mem_addr_o);
        n_rd++;
      end
      if (hold) chk("lane_hold", lane_data_o, held);
      if (lane_valid_o && lane_ready_i) begin
        lane_log.push_back(lane_data_o);
        if (q_lane.size() == 0) chk("lane_extra", 1, 0);
        else chk("lane_data", lane_data_o, q_lane.pop_front());
      end
      hold = lane_valid_o && !lane_ready_i;
      held = lane_data_o;
      if (st_valid_i && st_ready_o) q_wr.push_back(pack_m(st_data_i, exp_mode));
      if (mem_wvalid_o && mem_wready_i) begin
        ea = exp_base + n_wr * exp_stride;
        chk("wr_addr", mem_addr_o, ea);
        if (q_wr.size() == 0) chk("wr_extra", 1, 0);
        else chk("wr_data", mem_wdata_o, q_wr.pop_front());
        addr_log.push_back(mem_addr_o);
        n_wr++;
      end
      if (done_o) done_cnt++;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic all_ready();
    mem_rvalid_i = 1; lane_ready_i = 1; mem_wready_i = 1; st_valid_i = 1; cmd_valid_i = 0;
  endtask
  task automatic rand_inputs();
    mem_rvalid_i = 1'($urandom_range(0, 1));
    lane_ready_i = 1'($urandom_range(0, 1));
    mem_wready_i = 1'($urandom_range(0, 1));
    st_valid_i = 1'($urandom_range(0, 1));
    for (int k = 0; k < 8; k++)
      st_data_i[16*k +: 16] = $urandom_range(0, 1) ? 16'($urandom_range(0, 400)) - 16'd200 : 16'($urandom);
    // Foreign commands while busy must be ignored
    cmd_valid_i = busy_o && $urandom_range(0, 3) == 0;
    cmd_dir_i = 1'($urandom_range(0, 1));
    cmd_mode_i = 1'($urandom_range(0, 1));
    cmd_base_i = $urandom;
    cmd_stride_i = $urandom;
    cmd_lines_i = 16'($urandom_range(0, 9));
  endtask
  task automatic start_cmd(input bit dir, input bit mode, input logic [31:0] base, input logic [31:0] stride, input logic [15:0] lines);
    for (int i = 0; i < 50 && !cmd_ready_o; i++) step();
    chk("cmd_ready", cmd_ready_o, 1);
    exp_base = base; exp_stride = stride; exp_mode = mode;
    n_rd = 0; n_wr = 0; done_cnt = 0;
    q_lane.delete(); q_wr.delete(); lane_log.delete(); addr_log.delete();
    cmd_dir_i = dir; cmd_mode_i = mode; cmd_base_i = base; cmd_stride_i = stride; cmd_lines_i = lines;
    cmd_valid_i = 1;
    step();
    cmd_valid_i = 0;
  endtask
  task automatic finish_cmd(input bit dir, input logic [15:0] lines, input bit rnd);
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      if (rnd) rand_inputs();
      else all_ready();
      step();
    end
    cmd_valid_i = 0;
    step();
    step();
    chk("done_once", done_cnt, 1);
    ea = exp_base + lines * exp_stride;
    chk("end_addr", mem_addr_o, ea);
    chk("lines_done", lines_done_o, lines);
    chk("xfer_cnt", dir ? n_wr : n_rd, lines);
    chk("other_cnt", dir ? n_rd : n_wr, 0);
    chk("q_left", q_lane.size() + q_wr.size(), 0);
    chk("idle_busy", busy_o, 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_lane_valid"}, lane_valid_o, 0);
    chk({tag, "_wvalid"}, mem_wvalid_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_lines_done"}, lines_done_o, 0);
    chk({tag, "_lane_data"}, lane_data_o, 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_rready"}, mem_rready_o, 0);
    chk({tag, "_st_ready"}, st_ready_o, 0);
    chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
  endtask
  initial begin
    int sv[8];
    logic [127:0] w;
    sv = '{300, -200, 5, -5, 127, -128, 0, 1000};
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk_zero("reset");
    step();
    // INT8 load, known word 0 at 0x100
    start_cmd(0, 0, 32'h100, 32'h8, 3);
    finish_cmd(0, 3, 0);
    lv = lane_log.size() > 0 ? lane_log[0] : '0;
    chk("int8_lanes", lv[63:0], {16'hFF80, 16'hFFFF, 16'h0001, 16'h007F});
    chk("int8_addr2", addr_log.size() == 3 ? addr_log[2] : 32'hX, 32'h110);
    // INT16 load with lane back-pressure after first beat
    start_cmd(0, 1, 32'h400, 32'h20, 4);
    mem_rvalid_i = 1; lane_ready_i = 1;
    for (int i = 0; i < 10 && !lane_valid_o; i++) step();
    lane_ready_i = 0;
    w = lane_data_o;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_rready", mem_rready_o, 0);
      chk("stall_data", lane_data_o, w);
      chk("stall_lines", lines_done_o, 1);
      step();
    end
    finish_cmd(0, 4, 0);
    chk("stall_outputs", lane_log.size(), 4);
    // INT8 store with saturation and write back-pressure
    start_cmd(1, 0, 32'h800, 32'h40, 2);
    for (int k = 0; k < 8; k++) st_data_i[16*k +: 16] = 16'(sv[k]);
    st_valid_i = 1; mem_wready_i = 0;
    for (int i = 0; i < 10 && !mem_wvalid_o; i++) step();
    @(negedge clk);
    w = mem_wdata_o;
    chk("pack_w0", w[31:0], 32'hFB05807F);
    chk("pack_w1", w[63:32], 32'h7F00807F);
    chk("pack_hi", w[127:64], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wstall_st_ready", st_ready_o, 0);
      chk("wstall_addr", mem_addr_o, 32'h800);
      step();
    end
    finish_cmd(1, 2, 0);
    // Zero-line command under full handshake pressure
    all_ready();
    start_cmd(1, 0, 32'h40, 32'h4, 0);
    all_ready();
    @(negedge clk);
    chk("zero_done_c1", done_o, 0);
    step();
    @(negedge clk);
    chk("zero_done_c2", done_o, 1);
    step();
    @(negedge clk);
    chk("zero_done_c3", done_o, 0);
    chk("zero_traffic", n_rd + n_wr, 0);
    chk("zero_lines", lines_done_o, 0);
    chk("zero_addr", mem_addr_o, 32'h40);
    step();
    // Address wrap
    start_cmd(1, 1, 32'hFFFFFFF8, 32'h10, 2);
    finish_cmd(1, 2, 1);
    chk("wrap_addr", addr_log.size() == 2 ? addr_log[1] : 32'hX, 32'h8);
    // Reset during line 2 of 5
    start_cmd(0, 0, 32'h200, 32'h4, 5);
    all_ready();
    for (int i = 0; i < 20 && lines_done_o < 1; i++) step();
    #2 rst_n = 0;
    #1 chk_zero("midreset");
    q_lane.delete(); q_wr.delete();
    mem_rvalid_i = 0; lane_ready_i = 0; mem_wready_i = 0; st_valid_i = 0;
    step();
    rst_n = 1;
    step();
    start_cmd(0, 0, 32'h300, 32'h8, 1);
    finish_cmd(0, 1, 0);
    // Randomized commands
    for (int t = 0; t < 14; t++) begin
      bit d, m;
      logic [15:0] n;
      d = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      n = 16'($urandom_range(1, 6));
      start_cmd(d, m, $urandom, $urandom, n);
      finish_cmd(d, n, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
